// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, per-opcode execute steps T3-T7, and a HALT sink.
// Enables decode from the current state plus IR/CON/mem_ready; the memory waits stretch T1 and ld T6.
module control_unit (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic        InPortout,
  output logic        OutPortin,
  output logic [4:0]  alu_op,
  output logic        run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  state_t     r_state;
  state_t     w_next;
  logic       w_last;
  logic [4:0] w_op;
  logic       w_is_r, w_is_imm, w_is_md, w_is_un, w_is_mem, w_zero;
  logic       w_unused;

  assign w_op     = IR[31:27];
  assign w_unused = ^IR[26:0];
  assign w_is_r   = (w_op >= 5'd3)  && (w_op <= 5'd10);
  assign w_is_imm = (w_op >= 5'd11) && (w_op <= 5'd13);
  assign w_is_md  = (w_op == 5'd14) || (w_op == 5'd15);
  assign w_is_un  = (w_op == 5'd16) || (w_op == 5'd17);
  assign w_is_mem = (w_op <= OP_ST);
  assign w_zero   = (w_op == OP_NOP) || (w_op > OP_HALT);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0; CONin = 1'b0;
    InPortout = 1'b0; OutPortin = 1'b0;
    alu_op = 5'd0;
    run    = (r_state != S_RST) && (r_state != S_HALT);
    w_last = 1'b0;
    w_next = r_state;
    case (r_state)
      S_RST: w_next = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        w_next = S_T1;
      end
      S_T1: begin
        // Incremented PC is committed only in the cycle the read completes.
        Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
        if (mem_ready) begin
          PCin = 1'b1;
          w_next = S_T2;
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        if (w_op == OP_HALT) w_next = S_HALT;
        else if (w_zero)     w_last = 1'b1;
        else                 w_next = S_T3;
      end
      S_T3: begin
        w_next = S_T4;
        if (w_is_r || w_is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_is_md) begin
          Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (w_is_un) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op;
        end else if (w_is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (w_op == OP_BR) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (w_op == OP_JAL) begin
          PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
        end else begin
          w_last = 1'b1;
          case (w_op)
            OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_T4: begin
        w_next = S_T5;
        if (w_is_r) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op;
        end else if (w_is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = w_op;
        end else if (w_is_md) begin
          Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_op;
        end else if (w_is_mem) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else if (w_op == OP_BR) begin
          PCout = 1'b1; Yin = 1'b1;
        end else begin
          w_last = 1'b1;
          if (w_is_un) begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (w_op == OP_JAL) begin
            Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
          end
        end
      end
      S_T5: begin
        w_next = S_T6;
        if (w_is_md) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (w_op == OP_BR) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
        end else begin
          w_last = 1'b1;
          if (w_is_r || w_is_imm || (w_op == OP_LDI)) begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
        end
      end
      S_T6: begin
        if (w_op == OP_LD) begin
          Read = 1'b1; MDRin = 1'b1;
          if (mem_ready) w_next = S_T7;
        end else if (w_op == OP_ST) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
          w_next = S_T7;
        end else begin
          w_last = 1'b1;
          if (w_is_md) begin
            Zhighout = 1'b1; HIin = 1'b1;
          end else if ((w_op == OP_BR) && CON) begin
            Zlowout = 1'b1; PCin = 1'b1;
          end
        end
      end
      S_T7: begin
        w_last = 1'b1;
        if (w_op == OP_LD) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (w_op == OP_ST) begin
          Write = 1'b1;
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_RST;
    endcase
    // stop is only honoured at an instruction boundary.
    if (w_last) w_next = stop ? S_HALT : S_T0;
  end

endmodule
